// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [FETCH_XLEN-1:0] NOP_INSTR       = 32'h0000_0013;
    localparam logic [FETCH_XLEN-1:0] IMEM_ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  fault;
    } fetch_entry_t;

    // A PC with any low bits set cannot be fetched from word-organised memory
    function automatic logic is_misaligned(input logic [FETCH_XLEN-1:0] pc);
        return |(pc & IMEM_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small decode-side buffer of fetched entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_push,
    input  T            i_push_data,
    input  logic        i_pop,
    output T            o_head,
    output logic [AW:0] o_count,
    output logic        o_empty,
    output logic        o_full
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer and occupancy tracking; clear takes priority over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Entry storage; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: imem request/response FSM feeding decode
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN       = FETCH_XLEN,
    parameter int FIFO_DEPTH = 2,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            pc_advance,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault,
    input  logic            id_ready
);

    fetch_state_e    r_state;
    logic            r_req_valid;
    logic [XLEN-1:0] r_req_addr;

    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_pop;
    logic            w_push_fault;
    logic            w_push_rsp;
    logic            w_handshake;
    logic            w_credit_after;
    logic            w_misaligned;

    assign w_misaligned = is_misaligned(pc_in);
    assign w_handshake  = r_req_valid && imem_req_ready;
    assign w_pop        = !w_fifo_empty && id_ready;

    // In IDLE nothing is outstanding, so credit reduces to "FIFO not full"
    assign w_push_fault = (r_state == IDLE) && !w_fifo_full && !flush && w_misaligned;
    assign w_push_rsp   = (r_state == WAIT) && imem_rsp_valid && !flush;

    // After a WAIT push, a new request may only go out if its response will fit
    assign w_credit_after = (int'(w_fifo_count) + 1 - int'(w_pop)) < FIFO_DEPTH;

    assign w_push_data = w_push_fault ? '{pc: pc_in, instr: NOP_INSTR, fault: 1'b1}
                                      : '{pc: r_req_addr, instr: imem_rsp_data, fault: imem_rsp_err};

    assign pc_advance     = w_handshake && !flush;
    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;

    assign id_valid = !w_fifo_empty;
    assign id_instr = w_fifo_empty ? NOP_INSTR : w_head.instr;
    assign id_pc    = w_fifo_empty ? '0 : w_head.pc;
    assign id_fault = w_fifo_empty ? 1'b0 : w_head.fault;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .i_clear     (flush),
        .i_push      (w_push_fault || w_push_rsp),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // Fetch FSM: issues one request per PC and tracks its single outstanding response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_full && !flush) begin
                        if (w_misaligned) begin
                            r_state <= HALT;
                        end else begin
                            r_req_addr  <= pc_in;
                            r_req_valid <= 1'b1;
                            r_state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush) begin
                        r_req_valid <= 1'b0;
                        r_state     <= imem_req_ready ? DROP : IDLE;
                    end else if (imem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        r_state <= imem_rsp_valid ? IDLE : DROP;
                    end else if (imem_rsp_valid) begin
                        if (w_credit_after) begin
                            r_req_addr  <= pc_in;
                            r_req_valid <= 1'b1;
                            r_state     <= REQ;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) r_state <= IDLE;
                end
                HALT: begin
                    if (flush) r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
